// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : Memory-access stage of the 24-bit pipeline. ALU-only
//                instructions pass straight through to MEM_to_WB in the same
//                cycle. Loads and stores run over a request/acknowledge
//                data-memory port while upstream is stalled, then the
//                captured instruction is presented for one cycle.
//
//  Ports
//    clk, rst                  clock, asynchronous active-high reset
//    valid_in                  EX/MEM holds a valid instruction
//    writeback_enable          instruction writes the register file
//    mem_read_enable           load
//    mem_write_enable          store
//    instruction_dest          destination register index
//    alu_result                ALU result / effective address
//    store_data                store operand
//    mem_req/mem_we            registered memory request / write strobe
//    mem_addr/mem_wdata        registered word address / write data
//    mem_ack/mem_rdata         one-cycle completion strobe / read data
//    stall                     upstream must hold its outputs
//    mem_error                 sticky: access timeout or address out of range
//    *_out                     bundle registered by MEM_to_WB
//
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_stage #(
    parameter int DATA_W  = 24,
    parameter int DEST_W  = 4,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              writeback_enable,
    input  logic              mem_read_enable,
    input  logic              mem_write_enable,
    input  logic [DEST_W-1:0] instruction_dest,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              mem_error,
    output logic              writeback_enable_out,
    output logic              mem_read_enable_out,
    output logic [DEST_W-1:0] instruction_dest_out,
    output logic [DATA_W-1:0] mem_read_data_out,
    output logic [DATA_W-1:0] alu_result_out
);

    // Counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [CNT_W-1:0]    r_cnt;
    logic                r_error;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    // Instruction captured on entry to a memory access
    logic [DEST_W-1:0]   r_dest;
    logic                r_wb;
    logic                r_load;
    logic [DATA_W-1:0]   r_alu;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_mem_op;
    logic                w_out_of_range;
    logic                w_timeout;

    assign w_mem_op       = valid_in & (mem_read_enable | mem_write_enable);
    assign w_out_of_range = |alu_result[DATA_W-1:ADDR_W];
    // An ack in the final allowed cycle takes precedence over the timeout.
    assign w_timeout      = (r_cnt == c_CNT_LAST) & ~mem_ack;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and output bundle
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt          = r_state;
        stall                = 1'b0;
        writeback_enable_out = 1'b0;
        mem_read_enable_out  = 1'b0;
        instruction_dest_out = '0;
        mem_read_data_out    = '0;
        alu_result_out       = '0;

        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    // Bubble towards writeback while the access is set up
                    stall       = 1'b1;
                    w_state_nxt = w_out_of_range ? S_DONE : S_ACCESS;
                end else begin
                    writeback_enable_out = valid_in & writeback_enable;
                    mem_read_enable_out  = valid_in & mem_read_enable;
                    instruction_dest_out = instruction_dest;
                    alu_result_out       = alu_result;
                end
            end
            S_ACCESS: begin
                stall = 1'b1;
                if (mem_ack || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Upstream still shows the same instruction; present the
                // captured copy and ignore the inputs.
                writeback_enable_out = r_wb;
                mem_read_enable_out  = r_load;
                instruction_dest_out = r_dest;
                mem_read_data_out    = r_rdata;
                alu_result_out       = r_alu;
                w_state_nxt          = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory port, timeout counter and captured instruction
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_error     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_dest      <= '0;
            r_wb        <= 1'b0;
            r_load      <= 1'b0;
            r_alu       <= '0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        r_dest  <= instruction_dest;
                        r_wb    <= writeback_enable;
                        r_load  <= mem_read_enable;
                        r_alu   <= alu_result;
                        r_rdata <= '0;
                        if (w_out_of_range) begin
                            r_error <= 1'b1;
                        end else begin
                            r_mem_addr  <= alu_result[ADDR_W-1:0];
                            r_mem_wdata <= store_data;
                            // Both enables set is treated as a load
                            r_mem_we    <= ~mem_read_enable;
                            r_mem_req   <= 1'b1;
                            r_cnt       <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        r_rdata   <= r_load ? mem_rdata : '0;
                        r_mem_req <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata   <= '0;
                        r_mem_req <= 1'b0;
                        r_error   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_error = r_error;

endmodule
`default_nettype wire
